mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Round-robin arbiter and sequencer for the single byte-wide main memory port. Requesters are the core's opcode fetch, LD/ST data access, and a debug/loader port. Each request is serialized into one or two byte cycles on the memory. Two-byte values are little-endian: byte at addr is the low byte, byte at addr+1 is the high byte, matching the core's opcode layout.

Parameters:
NREQ, 3, number of requesters (0 = fetch, 1 = load/store, 2 = debug).
WIDTH_WORD, 8, memory data width (`WIDTH_WORD).
WIDTH_DOUBLE, 16, address and double-word width (`WIDTH_DOUBLE).

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
req_valid  in  NREQ  request pending, per requester.
req_write  in  NREQ  1 = write, 0 = read.
req_dbl  in  NREQ  1 = two-byte access, 0 = one byte.
req_addr  in  NREQ*WIDTH_DOUBLE  byte address; requester i uses slice i.
req_wdata  in  NREQ*WIDTH_DOUBLE  write data; single-byte writes use [7:0].
req_ack  out  NREQ  completion strobe, one-hot.
req_rdata  out  WIDTH_DOUBLE  read data, valid while req_ack is nonzero.
grant_id  out  $clog2(NREQ)  requester currently or last granted.
busy  out  1  arbiter not IDLE.
mem_en  out  1  memory access this cycle.
mem_we  out  1  write strobe (qualified by mem_en).
mem_addr  out  WIDTH_DOUBLE  memory byte address.
mem_wdata  out  WIDTH_WORD  memory write byte.
mem_rdata  in  WIDTH_WORD  read byte; synchronous memory, valid the cycle after a read mem_en.

Behaviour:
- State machine: IDLE, BYTE0, BYTE1, ACK.
- Reset state: IDLE, rr pointer 0, grant_id 0, latched addr/wdata/flags 0.
- Reset outputs: mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, req_ack 0, req_rdata 0, busy 0.
- mem_en, mem_we and req_ack decode from state, so an async reset drops them immediately.
- IDLE:
  - If any req_valid is set, pick the winner: first set bit at or after ptr, wrapping modulo NREQ.
  - On the grant edge, latch the winner's addr, wdata, write and dbl, and set grant_id = winner.
  - Set ptr = (winner+1) mod NREQ; go to BYTE0.
  - No memory access occurs in IDLE.
- BYTE0:
  - mem_en 1, mem_addr = addr, mem_we = write, mem_wdata = wdata[7:0].
  - Next state is BYTE1 if dbl, else ACK.
- BYTE1:
  - mem_en 1, mem_addr = addr+1 (16-bit wrap, so 0xFFFF is followed by 0x0000), mem_we = write, mem_wdata = wdata[15:8].
  - Register mem_rdata (the byte0 result) into lo.
  - Next state is ACK.
- ACK:
  - mem_en 0; req_ack[grant_id] = 1 for exactly this cycle.
  - req_rdata for a read: single = {8'h00, mem_rdata}; dbl = {mem_rdata, lo}.
  - req_rdata for a write: 0.
  - Next state is IDLE.
- Latency, counted from the cycle req_valid is seen in IDLE as cycle 0: single access acks in cycle 2; double access acks in cycle 3.
- Throughput: back-to-back requests by different requesters are not possible; ACK is always followed by IDLE, so each transaction is 3 or 4 cycles.
- Requester rules:
  - Hold req_valid and the request fields until the ack.
  - Fields are sampled only at the grant edge; later changes are ignored.
  - Dropping req_valid after grant does not cancel the transaction.
  - A requester still holding req_valid at the edge ending ACK has issued a new request; it competes in the next IDLE under round-robin.
- Fairness: with all NREQ requesters held valid, grants rotate 0,1,...,NREQ-1,0, and no requester waits more than NREQ-1 transactions.
- Reset mid-transaction: abort with no ack, and any write in progress may be partial. Requesters reissue after reset.
- req_valid bits at or above NREQ do not exist; X on a non-granted requester's fields must not propagate.

Decomposition:
- const.v gains `ARB_IDLE, `ARB_BYTE0, `ARB_BYTE1, `ARB_ACK (2-bit) and requester IDs `REQ_FETCH=0, `REQ_LDST=1, `REQ_DBG=2.
- Reuse the existing `WIDTH_WORD and `WIDTH_DOUBLE.
- One sub-module, mem_rr_pick: combinational round-robin picker taking req vector and ptr, producing winner index and a found flag; tested standalone.

Test Plan:
- Single read: mem[0x0007]=0x31, req1 reads 0x0007 single -> cycle 1: mem_en=1, addr 0x0007, we=0; cycle 2: req_ack=3'b010, req_rdata=0x0031.
- Double read: mem[6]=0x08, mem[7]=0x31, req0 dbl read 0x0006 -> BYTE0 addr 0x0006, BYTE1 addr 0x0007; ack[0] in cycle 3 with req_rdata=0x3108.
- Double write wrap: req2 dbl write 0xFFFF, wdata 0xBEEF -> write 0xEF at 0xFFFF, then 0xBE at 0x0000; ack[2] with rdata 0.
- Fairness: after reset, hold all three req_valid -> grant_id sequence 0,1,2,0,1,2; each ack one-hot, none repeated before the others.
- Pointer priority: after a grant to req0 (ptr=1), assert req0 and req2 together -> req2 granted first, then req0.
- Reset in BYTE1 of a dbl read -> mem_en and busy drop the same cycle, no ack; after release, req0 and req1 both valid -> req0 granted.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and state encoding for the byte-wide memory port arbiter.
package mem_arbiter_pkg;

  localparam int DEF_NREQ         = 3;
  localparam int DEF_WIDTH_WORD   = 8;
  localparam int DEF_WIDTH_DOUBLE = 16;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BYTE0 = 2'd1,
    ARB_BYTE1 = 2'd2,
    ARB_ACK   = 2'd3
  } arb_state_t;

  localparam logic [1:0] REQ_FETCH = 2'd0;
  localparam logic [1:0] REQ_LDST  = 2'd1;
  localparam logic [1:0] REQ_DBG   = 2'd2;

  // Index width that stays legal for a single requester.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module mem_rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IDW  = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  winner,
  output logic            found
);

  logic [IDW-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serializes one- or two-byte requests onto a byte-wide
// synchronous memory; two-byte values are little-endian.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter  int NREQ         = DEF_NREQ,
  parameter  int WIDTH_WORD   = DEF_WIDTH_WORD,
  parameter  int WIDTH_DOUBLE = DEF_WIDTH_DOUBLE,
  localparam int IDW          = id_w(NREQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0]              req_write,
  input  logic [NREQ-1:0]              req_dbl,
  input  logic [NREQ*WIDTH_DOUBLE-1:0] req_addr,
  input  logic [NREQ*WIDTH_DOUBLE-1:0] req_wdata,
  output logic [NREQ-1:0]              req_ack,
  output logic [WIDTH_DOUBLE-1:0]      req_rdata,
  output logic [IDW-1:0]               grant_id,
  output logic                         busy,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [WIDTH_DOUBLE-1:0]      mem_addr,
  output logic [WIDTH_WORD-1:0]        mem_wdata,
  input  logic [WIDTH_WORD-1:0]        mem_rdata
);

  arb_state_t              state;
  logic [IDW-1:0]          ptr;
  logic [IDW-1:0]          winner;
  logic                    found;
  logic [WIDTH_DOUBLE-1:0] addr;
  logic [WIDTH_DOUBLE-1:0] wdata;
  logic                    write;
  logic                    dbl;
  logic [WIDTH_WORD-1:0]   lo;

  mem_rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req_valid),
    .ptr    (ptr),
    .winner (winner),
    .found  (found)
  );

  // Only the winner's slice is latched, so X on other requesters never enters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      ptr      <= '0;
      grant_id <= '0;
      addr     <= '0;
      wdata    <= '0;
      write    <= 1'b0;
      dbl      <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (found) begin
            addr     <= req_addr[int'(winner)*WIDTH_DOUBLE +: WIDTH_DOUBLE];
            wdata    <= req_wdata[int'(winner)*WIDTH_DOUBLE +: WIDTH_DOUBLE];
            write    <= req_write[winner];
            dbl      <= req_dbl[winner];
            grant_id <= winner;
            ptr      <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
            state    <= ARB_BYTE0;
          end
        end
        ARB_BYTE0: state <= dbl ? ARB_BYTE1 : ARB_ACK;
        ARB_BYTE1: state <= ARB_ACK;
        default:   state <= ARB_IDLE;
      endcase
    end
  end

  // Low byte of a double read arrives during BYTE1.
  always_ff @(posedge clk) begin
    if (state == ARB_BYTE1) lo <= mem_rdata;
  end

  assign busy      = (state != ARB_IDLE);
  assign mem_en    = (state == ARB_BYTE0) || (state == ARB_BYTE1);
  assign mem_we    = mem_en && write;
  assign mem_addr  = (state == ARB_BYTE1) ? addr + WIDTH_DOUBLE'(1) : addr;
  assign mem_wdata = (state == ARB_BYTE1) ? wdata[2*WIDTH_WORD-1 -: WIDTH_WORD]
                                          : wdata[WIDTH_WORD-1:0];

  always_comb begin
    req_ack   = '0;
    req_rdata = '0;
    if (state == ARB_ACK) begin
      req_ack[grant_id] = 1'b1;
      if (!write) begin
        req_rdata = dbl ? WIDTH_DOUBLE'({mem_rdata, lo})
                        : {{(WIDTH_DOUBLE-WIDTH_WORD){1'b0}}, mem_rdata};
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model and a byte memory.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid, req_write, req_dbl, req_ack;
  logic [N*16-1:0] req_addr, req_wdata;
  logic [15:0]     req_rdata, mem_addr;
  logic [1:0]      grant_id;
  logic            busy, mem_en, mem_we;
  logic [7:0]      mem_wdata, mem_rdata;

  logic            bd_we;
  logic [15:0]     bd_addr;
  logic [7:0]      bd_data;
  logic [7:0]      mem     [0:65535];
  logic [7:0]      ref_mem [0:65535];

  int checks   = 0;
  int failures = 0;
  int mptr     = 0;

  mem_arbiter #(.NREQ(N), .WIDTH_WORD(8), .WIDTH_DOUBLE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_dbl   (req_dbl),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ack   (req_ack),
    .req_rdata (req_rdata),
    .grant_id  (grant_id),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous byte memory with a backdoor load port.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  function automatic logic [15:0] rnd_addr();
    logic [15:0] a;
    a = 16'($urandom_range(0, 15));
    if ($urandom_range(0, 1) == 1) a = a | 16'hFFF0;
    return a;
  endfunction

  task automatic set_req(input int i, input bit v, input bit w, input bit d,
                         input logic [15:0] a, input logic [15:0] wd);
    req_valid[i] = v; req_write[i] = w; req_dbl[i] = d;
    req_addr[i*16 +: 16] = a; req_wdata[i*16 +: 16] = wd;
  endtask

  function automatic int model_pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction

  // Runs one transaction starting in IDLE (#1 after an edge); returns in the next IDLE.
  task automatic do_txn(output int gid, output logic [15:0] rd, input bit keep);
    int w;
    logic [15:0] a, a1, wd, exp_rd;
    bit wr, db;
    gid = -1; rd = '0;
    w = model_pick(req_valid);
    if (w < 0) begin
      check("txn_has_request", 0, 1);
      return;
    end
    a = req_addr[w*16 +: 16]; wd = req_wdata[w*16 +: 16];
    wr = req_write[w]; db = req_dbl[w]; a1 = a + 16'd1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_mem_en", mem_en, 0);
    @(posedge clk); #1;
    req_addr[w*16 +: 16]  = rnd_addr();
    req_wdata[w*16 +: 16] = 16'($urandom);
    req_write[w] = 1'($urandom); req_dbl[w] = 1'($urandom);
    if (!keep) req_valid[w] = 1'b0;
    mptr = (w + 1) % N;
    @(negedge clk);
    gid = int'(grant_id);
    check("b0_grant", grant_id, w);
    check("b0_busy", busy, 1);
    check("b0_mem_en", mem_en, 1);
    check("b0_mem_we", mem_we, wr);
    check("b0_addr", mem_addr, a);
    check("b0_wdata", mem_wdata, wd[7:0]);
    check("b0_ack", req_ack, 0);
    if (db) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("b1_mem_en", mem_en, 1);
      check("b1_mem_we", mem_we, wr);
      check("b1_addr", mem_addr, a1);
      check("b1_wdata", mem_wdata, wd[15:8]);
      check("b1_ack", req_ack, 0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    exp_rd = wr ? 16'h0000 : (db ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]});
    check("ack_onehot", req_ack, 32'd1 << w);
    check("ack_rdata", req_rdata, exp_rd);
    check("ack_mem_en", mem_en, 0);
    check("ack_busy", busy, 1);
    rd = req_rdata;
    if (wr) begin
      ref_mem[a] = wd[7:0];
      if (db) ref_mem[a1] = wd[15:8];
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [15:0] rd;
    req_valid = '0; req_write = '0; req_dbl = '0; req_addr = '0; req_wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_req_ack", req_ack, 0);
    check("rst_req_rdata", req_rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    @(posedge clk); #1;
    for (int i = 0; i <= 16; i++) poke(16'(i), 8'($urandom));
    for (int i = 0; i < 16; i++) poke(16'hFFF0 | 16'(i), 8'($urandom));
    poke(16'h0006, 8'h08);
    poke(16'h0007, 8'h31);
    rst = 1'b0; mptr = 0;
    @(posedge clk); #1;

    set_req(int'(REQ_LDST), 1, 0, 0, 16'h0007, 16'h0000);
    do_txn(g, rd, 0);
    check("tp_single_id", g, 1);
    check("tp_single_rdata", rd, 16'h0031);

    set_req(int'(REQ_FETCH), 1, 0, 1, 16'h0006, 16'h0000);
    do_txn(g, rd, 0);
    check("tp_double_id", g, 0);
    check("tp_double_rdata", rd, 16'h3108);

    set_req(int'(REQ_DBG), 1, 1, 1, 16'hFFFF, 16'hBEEF);
    do_txn(g, rd, 0);
    check("tp_wrap_id", g, 2);
    check("tp_wrap_rdata", rd, 16'h0000);
    check("tp_wrap_lo_byte", mem[16'hFFFF], 8'hEF);
    check("tp_wrap_hi_byte", mem[16'h0000], 8'hBE);

    set_req(0, 1, 0, 0, 16'h0003, 16'h0000);
    do_txn(g, rd, 0);
    check("tp_prio_setup", g, 0);
    set_req(0, 1, 0, 0, 16'h0004, 16'h0000);
    set_req(2, 1, 0, 1, 16'h0005, 16'h0000);
    do_txn(g, rd, 0);
    check("tp_prio_first", g, 2);
    do_txn(g, rd, 0);
    check("tp_prio_second", g, 0);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mptr = 0;
    for (int i = 0; i < N; i++) set_req(i, 1, 0, 1'($urandom), rnd_addr(), 16'h0000);
    for (int i = 0; i < 6; i++) begin
      do_txn(g, rd, 1);
      check("tp_fair_seq", g, i % N);
    end
    req_valid = '0;
    @(posedge clk); #1;

    set_req(0, 1, 0, 1, 16'h0004, 16'h0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid_b1_en", mem_en, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_mem_en", mem_en, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_ack", req_ack, 0);
    @(posedge clk); #1;
    check("rstmid_no_ack", req_ack, 0);
    rst = 1'b0; mptr = 0;
    set_req(0, 1, 0, 0, 16'h0002, 16'h0000);
    set_req(1, 1, 0, 0, 16'h0003, 16'h0000);
    req_valid[2] = 1'b0;
    do_txn(g, rd, 0);
    check("rstmid_regrant", g, 0);

    for (int it = 0; it < 300; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0)
          set_req(i, 1, 1'($urandom), 1'($urandom), rnd_addr(), 16'($urandom));
      end
      if (req_valid == '0) begin
        g = $urandom_range(0, N - 1);
        set_req(g, 1, 1'($urandom), 1'($urandom), rnd_addr(), 16'($urandom));
      end
      do_txn(g, rd, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
